// File: rtl/sn74ls162_counter.sv
// SN74LS162 synchronous decade counter: sync clear/load, ripple carry.
// Define TTL_DELAY_EN to add T_CLK_Q / T_RCO output delays.
module sn74ls162_counter #(
  parameter int T_CLK_Q = 20,
  parameter int T_RCO   = 15
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load_n,
  input  logic       enp,
  input  logic       ent,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       rco
);

  logic [3:0] cnt_nxt;
  logic [3:0] q_nxt;
  logic [3:0] ctl;

  assign ctl = {clr_n, load_n, enp, ent};

  // Decade step; states 10..15 fold back into 0..9 within two counts.
  always_comb begin
    cnt_nxt = 4'd0;
    case (q)
      4'd0:  cnt_nxt = 4'd1;
      4'd1:  cnt_nxt = 4'd2;
      4'd2:  cnt_nxt = 4'd3;
      4'd3:  cnt_nxt = 4'd4;
      4'd4:  cnt_nxt = 4'd5;
      4'd5:  cnt_nxt = 4'd6;
      4'd6:  cnt_nxt = 4'd7;
      4'd7:  cnt_nxt = 4'd8;
      4'd8:  cnt_nxt = 4'd9;
      4'd9:  cnt_nxt = 4'd0;
      4'd10: cnt_nxt = 4'd11;
      4'd11: cnt_nxt = 4'd6;
      4'd12: cnt_nxt = 4'd13;
      4'd13: cnt_nxt = 4'd4;
      4'd14: cnt_nxt = 4'd15;
      4'd15: cnt_nxt = 4'd2;
      default: cnt_nxt = 4'bxxxx;
    endcase
  end

  // Control priority clear > load > count > hold; unknown control
  // falls to the default and poisons q instead of picking a branch.
  always_comb begin
    q_nxt = q;
    case (ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111:
        q_nxt = 4'd0;
      4'b1000, 4'b1001, 4'b1010, 4'b1011:
        q_nxt = d;
      4'b1111:
        q_nxt = cnt_nxt;
      4'b1100, 4'b1101, 4'b1110:
        q_nxt = q;
      default:
        q_nxt = 4'bxxxx;
    endcase
  end

`ifdef TTL_DELAY_EN
  // State register with TTL clock-to-q delay.
  always_ff @(posedge clk) begin
    q <= #T_CLK_Q q_nxt;
  end

  assign #T_RCO rco = ent & (q == 4'd9);
`else
  localparam int unused_delays = T_CLK_Q + T_RCO;

  // State register, zero-delay functional model.
  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

  assign rco = ent & (q == 4'd9);
`endif

endmodule

// File: tb/tb_sn74ls162_counter.sv
// Directed testbench for sn74ls162_counter.
// Single unit plus a two-decade cascade through rco.
module tb_sn74ls162_counter;

`ifdef TTL_DELAY_EN
  localparam int SMP = 40;
`else
  localparam int SMP = 1;
`endif

  logic       clk;
  logic       clr_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco;

  logic       c_clr_n;
  logic       c_en;
  logic       c_load_n;
  logic [3:0] c_d;
  logic [3:0] qu;
  logic [3:0] qt;
  logic       rco_u;
  logic       rco_t;

  int errors;
  int checks;

  sn74ls162_counter dut (
    .clk(clk), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent), .d(d), .q(q), .rco(rco)
  );

  sn74ls162_counter u_units (
    .clk(clk), .clr_n(c_clr_n), .load_n(c_load_n),
    .enp(c_en), .ent(c_en), .d(c_d), .q(qu), .rco(rco_u)
  );

  sn74ls162_counter u_tens (
    .clk(clk), .clr_n(c_clr_n), .load_n(c_load_n),
    .enp(rco_u), .ent(rco_u), .d(c_d), .q(qt), .rco(rco_t)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task step();
    @(posedge clk);
    #SMP;
  endtask

  task test_reset();
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b1; d = 4'd0;
    step();
    checks++;
    if (q !== 4'd0) begin
      errors++; $display("FAIL reset_q got=%b exp=0000", q);
    end
    checks++;
    if (rco !== 1'b0) begin
      errors++; $display("FAIL reset_rco got=%b exp=0", rco);
    end
    clr_n = 1'b1; load_n = 1'b0; d = 4'd5;
    step();
    clr_n = 1'b0; load_n = 1'b0; d = 4'd7;
    step();
    checks++;
    if (q !== 4'd0) begin
      errors++; $display("FAIL clr_over_load got=%b exp=0000", q);
    end
  endtask

  task test_count();
    logic [3:0] exp;
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    step();
    clr_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = 4'(i % 10);
      checks++;
      if (q !== exp) begin
        errors++; $display("FAIL count_q[%0d] got=%b exp=%b", i, q, exp);
      end
      checks++;
      if (rco !== (exp == 4'd9)) begin
        errors++;
        $display("FAIL count_rco[%0d] got=%b exp=%b", i, rco, exp == 4'd9);
      end
    end
  endtask

  task test_illegal();
    logic [3:0] seq [3][4];
    seq = '{'{4'd10, 4'd11, 4'd6, 4'd7},
            '{4'd12, 4'd13, 4'd4, 4'd5},
            '{4'd14, 4'd15, 4'd2, 4'd3}};
    for (int s = 0; s < 3; s++) begin
      clr_n = 1'b1; load_n = 1'b0; enp = 1'b1; ent = 1'b1;
      d = seq[s][0];
      step();
      load_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        checks++;
        if (q !== seq[s][k] || rco !== 1'b0) begin
          errors++;
          $display("FAIL illegal[%0d][%0d] got=%b rco=%b exp=%b rco=0",
                   s, k, q, rco, seq[s][k]);
        end
      end
    end
  endtask

  task test_enable();
    clr_n = 1'b1; load_n = 1'b0; d = 4'd9; enp = 1'b1; ent = 1'b1;
    step();
    load_n = 1'b1; enp = 1'b0;
    step();
    checks++;
    if (q !== 4'd9 || rco !== 1'b1) begin
      errors++;
      $display("FAIL enp_hold got=%b rco=%b exp=1001 rco=1", q, rco);
    end
    ent = 1'b0;
    #1;
    checks++;
    if (rco !== 1'b0) begin
`ifndef TTL_DELAY_EN
      errors++; $display("FAIL ent_gate_rco got=%b exp=0", rco);
`endif
    end
    enp = 1'b1;
    step();
    checks++;
    if (q !== 4'd9 || rco !== 1'b0) begin
      errors++;
      $display("FAIL ent_hold got=%b rco=%b exp=1001 rco=0", q, rco);
    end
  endtask

  task test_priority();
    clr_n = 1'b1; load_n = 1'b0; d = 4'd5; enp = 1'b1; ent = 1'b1;
    step();
    checks++;
    if (q !== 4'd5) begin
      errors++; $display("FAIL load_over_count got=%b exp=0101", q);
    end
    load_n = 1'b1; enp = 1'b0;
    #10 d = 4'd3; load_n = 1'b0;
    #10 load_n = 1'b1;
    step();
    checks++;
    if (q !== 4'd5) begin
      errors++; $display("FAIL midcycle_glitch got=%b exp=0101", q);
    end
    clr_n = 1'b0; enp = 1'b1; ent = 1'b1;
    step();
    clr_n = 1'b1;
    checks++;
    if (q !== 4'd0) begin
      errors++; $display("FAIL clr_with_en got=%b exp=0000", q);
    end
    step();
    checks++;
    if (q !== 4'd1) begin
      errors++; $display("FAIL first_count got=%b exp=0001", q);
    end
  endtask

  task test_cascade();
    logic [3:0] eu;
    logic [3:0] et;
    c_clr_n = 1'b0; c_load_n = 1'b1; c_en = 1'b0; c_d = 4'd0;
    step();
    c_clr_n = 1'b1; c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      eu = 4'(i % 10);
      et = 4'((i / 10) % 10);
      checks++;
      if (qu !== eu || qt !== et) begin
        errors++;
        $display("FAIL cascade[%0d] got=%0d%0d exp=%0d%0d",
                 i, qt, qu, et, eu);
      end
    end
  endtask

`ifdef TTL_DELAY_EN
  task test_delay();
    clr_n = 1'b1; load_n = 1'b0; d = 4'd8; enp = 1'b1; ent = 1'b1;
    step();
    load_n = 1'b1;
    @(posedge clk);
    #19;
    checks++;
    if (q !== 4'd8) begin
      errors++; $display("FAIL tcq_early got=%b exp=1000", q);
    end
    #2;
    checks++;
    if (q !== 4'd9 || rco !== 1'b0) begin
      errors++; $display("FAIL tcq got=%b rco=%b exp=1001 rco=0", q, rco);
    end
    #15;
    checks++;
    if (rco !== 1'b1) begin
      errors++; $display("FAIL trco got=%b exp=1", rco);
    end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    c_clr_n = 1'b0; c_load_n = 1'b1; c_en = 1'b0; c_d = 4'd0;
    #20;
    test_reset();
    test_count();
    test_illegal();
    test_enable();
    test_priority();
    test_cascade();
`ifdef TTL_DELAY_EN
    test_delay();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
